midi_out_arbiter: RTL and testbench

Shares one MIDI output serializer between `PORTS` byte-stream requesters (parsed MIDI input ports routed to the same output). It grants round-robin at MIDI-message granularity, so messages from different sources never interleave. It re-inserts running-status bytes when the output's running status differs from the granted source's, and releases a stalled grant after a timeout. One instance sits in front of each output-port transmitter inside the MIDI controller.

---
 rtl/midi_out_arbiter_if.sv | 24 ++
 rtl/midi_out_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_midi_out_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_out_arbiter_if.sv
// Requester byte lanes, serializer handshake and status for midi_out_arbiter.
// master = requesters/serializer side, slave = arbiter side.
interface midi_out_arbiter_if #(
  parameter int PORTS = 4
);
  logic [PORTS-1:0]   req_valid;
  logic [8*PORTS-1:0] req_data;
  logic [PORTS-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [PORTS-1:0]   grant;
  logic               busy;

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy
  );

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy
  );
endinterface

// File: rtl/midi_out_arbiter.sv
// Round-robin MIDI message arbiter with running-status re-insertion and stall timeout.
// Latency: accepted byte on tx one cycle later; req_ready follows tx_ready combinationally.
module midi_out_arbiter #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 12_000
) (
  input logic               clk,
  input logic               rst,
  midi_out_arbiter_if.slave bus
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INS   = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_SYSEX = 2'd3;

  logic [1:0]    r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [7:0]    r_rs [PORTS];
  logic [7:0]    r_out_rs;
  logic [1:0]    r_remain;
  logic          r_first;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic          w_free;
  logic          w_xfer;
  logic          w_own_vld;
  logic [7:0]    w_own_dat;
  logic [7:0]    w_rs_own;
  logic          w_rt;
  logic          w_unexp;
  logic          w_take;
  logic          w_drop;
  logic          w_fwd;
  logic          w_progress;
  logic          w_tmo_hit;
  logic          w_last_byte;
  logic          w_end;
  logic          w_any;
  logic [IW-1:0] w_pick;
  logic          w_pick_msb;
  logic [7:0]    w_pick_rs;
  logic          w_need_ins;
  logic [PORTS-1:0] w_grant;

  // Message length from its first status byte (running status uses this minus one).
  function automatic logic [1:0] f_len(input logic [7:0] b);
    if (b[7:4] == 4'hC || b[7:4] == 4'hD || b == 8'hF1 || b == 8'hF3)
      return 2'd2;
    else if ((b[7:4] >= 4'h8 && b[7:4] <= 4'hB) || b[7:4] == 4'hE || b == 8'hF2)
      return 2'd3;
    else
      return 2'd1;
  endfunction

  assign w_free    = !r_tx_valid || bus.tx_ready;
  assign w_xfer    = (r_state == S_XFER) || (r_state == S_SYSEX);
  assign w_own_vld = bus.req_valid[r_owner];
  assign w_own_dat = bus.req_data[8*r_owner +: 8];
  assign w_rs_own  = r_rs[r_owner];
  assign w_rt      = (w_own_dat >= 8'hF8);

  // A non-realtime status byte after the first byte ends the message without being consumed.
  assign w_unexp = w_own_vld && w_own_dat[7] && !w_rt &&
                   ((r_state == S_XFER && !r_first) ||
                    (r_state == S_SYSEX && w_own_dat != 8'hF7));

  assign w_take     = w_xfer && w_own_vld && w_free && !w_unexp;
  assign w_drop     = (r_state == S_XFER) && r_first && !w_own_dat[7] && !w_rs_own[7];
  assign w_fwd      = w_take && !w_drop;
  assign w_progress = w_take || (r_state == S_INS && w_free);
  assign w_tmo_hit  = (r_state != S_IDLE) && w_free && !w_progress && !w_unexp &&
                      (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_last_byte = 1'b0;
    if (r_state == S_SYSEX)
      w_last_byte = (w_own_dat == 8'hF7);
    else if (!r_first)
      w_last_byte = !w_rt && (r_remain == 2'd1);
    else if (w_rt)
      w_last_byte = 1'b1;
    else if (!w_own_dat[7])
      w_last_byte = !w_rs_own[7] || (f_len(w_rs_own) == 2'd2);
    else
      w_last_byte = (w_own_dat != 8'hF0) && (f_len(w_own_dat) == 2'd1);
  end

  assign w_end = w_unexp || w_tmo_hit || (w_take && w_last_byte);

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (!w_any && bus.req_valid[(int'(r_last) + k) % PORTS]) begin
        w_any  = 1'b1;
        w_pick = IW'((int'(r_last) + k) % PORTS);
      end
    end
  end

  assign w_pick_msb = bus.req_data[8*w_pick + 7];
  assign w_pick_rs  = r_rs[w_pick];
  assign w_need_ins = !w_pick_msb && w_pick_rs[7] && (r_out_rs != w_pick_rs);

  always_comb begin
    w_grant = '0;
    if (r_state != S_IDLE)
      w_grant[r_owner] = 1'b1;
  end

  assign bus.grant     = w_grant;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.req_ready = w_grant & {PORTS{w_xfer && w_free && !w_unexp}};
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= IW'(PORTS - 1);
      r_out_rs   <= '0;
      r_remain   <= '0;
      r_first    <= 1'b0;
      r_tmo      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      for (int i = 0; i < PORTS; i++)
        r_rs[i] <= '0;
    end else begin
      if (w_free)
        r_tx_valid <= 1'b0;
      if (w_fwd) begin
        r_tx_data  <= w_own_dat;
        r_tx_valid <= 1'b1;
      end

      if (r_state == S_IDLE || w_progress)
        r_tmo <= '0;
      else if (w_free)
        r_tmo <= r_tmo + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_first <= 1'b1;
            r_state <= w_need_ins ? S_INS : S_XFER;
          end
        end
        S_INS: begin
          if (w_free) begin
            r_tx_data  <= w_rs_own;
            r_tx_valid <= 1'b1;
            r_out_rs   <= w_rs_own;
            r_state    <= S_XFER;
          end
        end
        default: ;
      endcase

      if (w_take) begin
        r_first <= 1'b0;
        if (r_state == S_SYSEX) begin
          if (w_own_dat == 8'hF7) begin
            r_rs[r_owner] <= '0;
            r_out_rs      <= '0;
          end
        end else if (r_first) begin
          if (!w_own_dat[7]) begin
            r_remain <= f_len(w_rs_own) - 2'd2;
          end else if (!w_rt) begin
            r_remain <= f_len(w_own_dat) - 2'd1;
            if (w_own_dat < 8'hF0) begin
              r_rs[r_owner] <= w_own_dat;
              r_out_rs      <= w_own_dat;
            end else begin
              r_rs[r_owner] <= '0;
              r_out_rs      <= '0;
              if (w_own_dat == 8'hF0)
                r_state <= S_SYSEX;
            end
          end
        end else if (!w_rt) begin
          r_remain <= r_remain - 2'd1;
        end
      end

      if (w_end) begin
        r_state <= S_IDLE;
        r_last  <= r_owner;
      end
      if (w_unexp || w_tmo_hit)
        r_out_rs <= '0;
    end
  end
endmodule

// File: tb/tb_midi_out_arbiter.sv
// Scoreboard bench for midi_out_arbiter: per-port byte drivers, expected tx stream queue,
// independent tx monitor, plus directed timing/timeout/reset checks.
module tb_midi_out_arbiter;
  localparam int PORTS   = 4;
  localparam int TIMEOUT = 12_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  midi_out_arbiter_if #(.PORTS(PORTS)) bus();

  midi_out_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] drv_q [PORTS][$];
  logic       drv_vld [PORTS];
  logic [7:0] drv_dat [PORTS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      bus.req_valid[p]         = drv_vld[p];
      bus.req_data[8*p +: 8]   = drv_dat[p];
    end
  end

  // Per-port drivers: present queued bytes one at a time, hold until accepted.
  for (genvar p = 0; p < PORTS; p++) begin : g_drv
    initial begin : drv
      int   stall;
      logic took;
      drv_vld[p] = 1'b0;
      drv_dat[p] = 8'h00;
      stall = 0;
      forever begin
        @(negedge clk);
        took = drv_vld[p] && bus.req_ready[p];
        if (drv_vld[p] && !took) begin
          stall++;
          if (stall > 20000) begin
            n_checks++;
            $display("FAIL drv_accept port %0d: byte %02h not accepted, expected acceptance", p, drv_dat[p]);
          end
        end
        @(posedge clk);
        #1;
        if (took || stall > 20000) begin
          drv_vld[p] = 1'b0;
          stall = 0;
        end
        if (!drv_vld[p] && drv_q[p].size() > 0) begin
          drv_dat[p] = drv_q[p].pop_front();
          drv_vld[p] = 1'b1;
        end
      end
    end
  end

  // Monitor: every byte the serializer takes must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", bus.tx_data);
      end else begin
        chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int p = 0; p < PORTS; p++)
      n += drv_q[p].size() + int'(drv_vld[p]);
    return n;
  endfunction

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (pending() != 0 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, pending(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_grant(input string name, input logic [PORTS-1:0] g, input int limit);
    int cnt;
    cnt = 0;
    while (bus.grant !== g && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, bus.grant, g);
  endtask

  task automatic push3(input int p, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drv_q[p].push_back(a);
    drv_q[p].push_back(b);
    drv_q[p].push_back(c);
  endtask

  task automatic expect3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",     bus.grant, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_tx_valid",  bus.tx_valid, 0);
    chk("rst_tx_data",   bus.tx_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;

    // Two simultaneous notes: port 0 wins first, port 2 follows.
    @(posedge clk);
    #1;
    push3(0, 8'h90, 8'h3C, 8'h64);
    push3(2, 8'h90, 8'h3C, 8'h64);
    expect3(8'h90, 8'h3C, 8'h64);
    expect3(8'h90, 8'h3C, 8'h64);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.req_valid == 0 && cnt < 10);
    chk("t1_req_seen", bus.req_valid, 4'b0101);
    @(negedge clk);
    chk("t1_grant_first", bus.grant, 4'b0001);
    chk("t1_tx_valid_lat1", bus.tx_valid, 0);
    @(negedge clk);
    chk("t1_tx_valid_lat2", bus.tx_valid, 1);
    wait_grant("t1_grant_second", 4'b0100, 20);
    drain("t1_drain");

    // Running status: port 3 changes out status, so port 1's data-first message gets B0 re-inserted.
    push3(1, 8'hB0, 8'h07, 8'h7F);
    expect3(8'hB0, 8'h07, 8'h7F);
    drain("t2a_drain");
    push3(3, 8'hB1, 8'h07, 8'h40);
    expect3(8'hB1, 8'h07, 8'h40);
    drain("t2b_drain");
    drv_q[1].push_back(8'h07);
    drv_q[1].push_back(8'h10);
    expect3(8'hB0, 8'h07, 8'h10);
    drain("t2c_drain");
    drv_q[1].push_back(8'h07);
    drv_q[1].push_back(8'h20);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h20);
    drain("t2d_drain");

    // SysEx from port 0 completes before port 1's note-off.
    drv_q[0].push_back(8'hF0);
    drv_q[0].push_back(8'h7E);
    drv_q[0].push_back(8'h01);
    drv_q[0].push_back(8'hF7);
    push3(1, 8'h80, 8'h40, 8'h00);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hF7);
    expect3(8'h80, 8'h40, 8'h00);
    drain("t3_drain");

    // Realtime byte inside a message is passed through.
    drv_q[2].push_back(8'h90);
    drv_q[2].push_back(8'hF8);
    drv_q[2].push_back(8'h3C);
    drv_q[2].push_back(8'h64);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'hF8);
    expect3(8'h3C, 8'h64, 8'h00);
    void'(exp_q.pop_back());
    drain("t5_drain");

    // Status byte arriving mid-message truncates it and starts a new one.
    drv_q[2].push_back(8'h90);
    drv_q[2].push_back(8'h3C);
    push3(2, 8'h80, 8'h40, 8'h00);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h3C);
    expect3(8'h80, 8'h40, 8'h00);
    drain("t5b_drain");

    // Stalled owner is released after the timeout; an orphan data byte is dropped.
    do_reset();
    drv_q[2].push_back(8'h90);
    drv_q[2].push_back(8'h3C);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h3C);
    drain("t4_drain");
    chk("t4_busy_held", bus.busy, 1);
    chk("t4_grant_held", bus.grant, 4'b0100);
    cnt = 0;
    while (bus.busy && cnt < TIMEOUT + 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_timeout_window", (cnt >= TIMEOUT - 20 && cnt <= TIMEOUT + 5) ? 32'd1 : 32'd0, 1);
    chk("t4_grant_released", bus.grant, 0);
    chk("t4_busy_released", bus.busy, 0);
    drv_q[3].push_back(8'h3C);
    drain("t4_orphan_consumed");
    chk("t4_orphan_idle", bus.busy, 0);

    // Backpressure stall holds tx stable; reset drops the message asynchronously.
    do_reset();
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    push3(0, 8'h90, 8'h3C, 8'h64);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.tx_valid && cnt < 20);
    chk("t6_first_byte", bus.tx_data, 8'h90);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t6_stall_data", bus.tx_data, 8'h90);
      chk("t6_stall_valid", bus.tx_valid, 1);
    end
    chk("t6_stall_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_tx_valid", bus.tx_valid, 0);
    chk("t6_async_grant", bus.grant, 0);
    chk("t6_async_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.tx_ready = 1'b1;
    drain("t6_orphans_dropped");
    chk("t6_idle_after", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
